// File: rtl/io_bridge_irq_if.sv
// CPU/device bus bundle for io_bridge_irq.
// slave: the bridge itself. master: the CPU plus the device models around it.
interface io_bridge_irq_if #(
    parameter int unsigned N_DEV  = 3,
    parameter int unsigned DATA_W = 32
);
    logic [31:0]             PrAddr;
    logic [DATA_W-1:0]       PrWD;
    logic                    PrWe;
    logic                    PrRe;
    logic [DATA_W-1:0]       PrRD;
    logic                    PrReady;
    logic [1:0]              DEV_Addr;
    logic [DATA_W-1:0]       DEV_WD;
    logic [N_DEV-1:0]        DEV_We;
    logic [N_DEV*DATA_W-1:0] DEV_RD;
    logic [N_DEV-1:0]        DEV_IRQ;
    logic [5:0]              HWInt;

    modport master (
        output PrAddr, PrWD, PrWe, PrRe, DEV_RD, DEV_IRQ,
        input  PrRD, PrReady, DEV_Addr, DEV_WD, DEV_We, HWInt
    );

    modport slave (
        input  PrAddr, PrWD, PrWe, PrRe, DEV_RD, DEV_IRQ,
        output PrRD, PrReady, DEV_Addr, DEV_WD, DEV_We, HWInt
    );
endinterface

// File: rtl/io_bridge_irq.sv
// CPU/peripheral bridge with an N_DEV-slot address decoder, registered read
// data with a one-cycle ready pulse, and an interrupt controller in slot N_DEV
// (IMASK, IPEND, IEDGE, STATUS) driving HWInt[5:0].
// Optional feature macro: IRQ_PRIO_EN (lowest-index priority on HWInt, VECTOR in STATUS).
module io_bridge_irq #(
    parameter int unsigned N_DEV      = 3,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_7F00,
    parameter int unsigned SLOT_SHIFT = 4,
    parameter int unsigned DATA_W     = 32
) (
    input  logic           clk,
    input  logic           rst,
    io_bridge_irq_if.slave bus
);
    typedef enum logic {IDLE, RESP} state_t;

    state_t            state;
    logic [N_DEV-1:0]  imask;
    logic [N_DEV-1:0]  ipend;
    logic [N_DEV-1:0]  iedge;
    logic [N_DEV-1:0]  prev_irq;
    logic              err;

    logic [31:0]       offset;
    logic [31:0]       slot;
    logic              in_range;
    logic              sel_dev;
    logic              sel_ctl;
    logic              accept;
    logic              do_wr;
    logic              do_rd;
    logic [1:0]        reg_sel;
    logic [DATA_W-1:0] dev_data;
    logic [DATA_W-1:0] ctl_data;
    logic [N_DEV-1:0]  active;
    logic [N_DEV-1:0]  hw_sel;
    logic [N_DEV-1:0]  w1c;
    logic [N_DEV-1:0]  rise;
    logic [2:0]        vector;

    assign bus.DEV_Addr = bus.PrAddr[3:2];
    assign bus.DEV_WD   = bus.PrWD;

    // Address decode; strobes are only honoured in IDLE, write beats read
    always_comb begin
        offset   = bus.PrAddr - BASE_ADDR;
        slot     = offset >> SLOT_SHIFT;
        in_range = (bus.PrAddr >= BASE_ADDR);
        sel_dev  = in_range && (slot < 32'(N_DEV));
        sel_ctl  = in_range && (slot == 32'(N_DEV));
        accept   = (state == IDLE) && (bus.PrWe || bus.PrRe);
        do_wr    = accept && bus.PrWe;
        do_rd    = accept && !bus.PrWe;
        reg_sel  = bus.PrAddr[3:2];
    end

    // One-hot device write enable in the accept cycle, killed by reset
    always_comb begin
        bus.DEV_We = '0;
        if (do_wr && sel_dev && !rst) begin
            for (int i = 0; i < int'(N_DEV); i++) begin
                if (slot == 32'(i)) bus.DEV_We[i] = 1'b1;
            end
        end
    end

    // Device read-data select
    always_comb begin
        dev_data = '0;
        for (int i = 0; i < int'(N_DEV); i++) begin
            if (slot == 32'(i)) dev_data = bus.DEV_RD[i*DATA_W +: DATA_W];
        end
    end

    // Interrupt selection: all masked pending bits, or lowest one with its vector
    always_comb begin
        active = ipend & imask;
`ifdef IRQ_PRIO_EN
        hw_sel = '0;
        vector = 3'd0;
        for (int i = int'(N_DEV) - 1; i >= 0; i--) begin
            if (active[i]) begin
                hw_sel    = '0;
                hw_sel[i] = 1'b1;
                vector    = 3'(i + 1);
            end
        end
`else
        hw_sel = active;
        vector = 3'd0;
`endif
    end

    // Controller register read view and per-cycle edge/W1C terms
    always_comb begin
        ctl_data = '0;
        case (reg_sel)
            2'd0: ctl_data = DATA_W'(imask);
            2'd1: ctl_data = DATA_W'(ipend);
            2'd2: ctl_data = DATA_W'(iedge);
            default: begin
                ctl_data[DATA_W-1] = err;
                ctl_data[2:0]      = vector;
            end
        endcase
        w1c  = (do_wr && sel_ctl && reg_sel == 2'd1) ? bus.PrWD[N_DEV-1:0] : '0;
        rise = bus.DEV_IRQ & ~prev_irq;
    end

    // Bus FSM, read capture, controller registers and interrupt pipeline
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            bus.PrRD    <= '0;
            bus.PrReady <= 1'b0;
            bus.HWInt   <= '0;
            imask       <= '0;
            ipend       <= '0;
            iedge       <= '0;
            prev_irq    <= '0;
            err         <= 1'b0;
        end else begin
            prev_irq    <= bus.DEV_IRQ;
            bus.HWInt   <= 6'(hw_sel);
            bus.PrReady <= 1'b0;
            for (int i = 0; i < int'(N_DEV); i++) begin
                if (iedge[i]) ipend[i] <= (ipend[i] & ~w1c[i]) | rise[i];
                else          ipend[i] <= bus.DEV_IRQ[i];
            end
            case (state)
                IDLE: begin
                    if (accept) begin
                        state       <= RESP;
                        bus.PrReady <= 1'b1;
                        if (!sel_dev && !sel_ctl) err <= 1'b1;
                        if (do_rd) begin
                            bus.PrRD <= sel_dev ? dev_data : (sel_ctl ? ctl_data : '0);
                        end
                        if (do_wr && sel_ctl) begin
                            case (reg_sel)
                                2'd0:    imask <= bus.PrWD[N_DEV-1:0];
                                2'd2:    iedge <= bus.PrWD[N_DEV-1:0];
                                2'd3:    err   <= 1'b0;
                                default: ;
                            endcase
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_io_bridge_irq.sv
// Self-checking bench for io_bridge_irq: directed scenarios plus randomized
// interrupt traffic checked against a cycle-stepped behavioural model.
module tb_io_bridge_irq;
    localparam int unsigned N_DEV  = 3;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned BASE   = 32'h7F00;
    localparam int unsigned CTL    = BASE + 16 * N_DEV;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_pass   = 0;

    // behavioural model state
    int unsigned m_mask, m_pend, m_edge, m_prev, m_hw;
    bit          m_err;
    logic [31:0] dev_rd [N_DEV];

    io_bridge_irq_if #(.N_DEV(N_DEV), .DATA_W(DATA_W)) bus ();

    io_bridge_irq #(
        .N_DEV(N_DEV), .BASE_ADDR(32'h0000_7F00), .SLOT_SHIFT(4), .DATA_W(DATA_W)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    always #5 clk = ~clk;

    function automatic bit is_mapped(int unsigned a);
        return (a >= BASE) && (((a - BASE) / 16) <= N_DEV);
    endfunction

    function automatic int unsigned slot_of(int unsigned a);
        return (a - BASE) / 16;
    endfunction

    function automatic int unsigned exp_vector();
        int unsigned act;
        act = m_pend & m_mask;
`ifdef IRQ_PRIO_EN
        for (int i = 0; i < int'(N_DEV); i++)
            if ((act >> i) & 1) return 32'(i + 1);
`endif
        return act & 0;
    endfunction

    function automatic int unsigned exp_read(int unsigned a);
        if (!is_mapped(a)) return 0;
        if (slot_of(a) < N_DEV) return dev_rd[slot_of(a)];
        case ((a >> 2) & 3)
            0: return m_mask;
            1: return m_pend;
            2: return m_edge;
            default: return (m_err ? 32'h8000_0000 : 0) | exp_vector();
        endcase
    endfunction

    // Advance the model by one clock edge using the inputs currently driven.
    // The bench never holds strobes into the response cycle, so any strobe is an accepted access.
    function automatic void model_step();
        int unsigned irq, act, w1c, nmask, nedge, a, d, all;
        all = (1 << N_DEV) - 1;
        if (rst) begin
            m_mask = 0; m_pend = 0; m_edge = 0; m_prev = 0; m_hw = 0; m_err = 0;
            return;
        end
        irq   = 32'(bus.DEV_IRQ);
        act   = m_pend & m_mask;
`ifdef IRQ_PRIO_EN
        m_hw  = act & (~act + 1);
`else
        m_hw  = act;
`endif
        w1c   = 0;
        nmask = m_mask;
        nedge = m_edge;
        if (bus.PrWe || bus.PrRe) begin
            a = bus.PrAddr;
            d = bus.PrWD;
            if (!is_mapped(a)) m_err = 1;
            else if (bus.PrWe && slot_of(a) == N_DEV) begin
                case ((a >> 2) & 3)
                    0: nmask = d & all;
                    1: w1c   = d & all;
                    2: nedge = d & all;
                    default: m_err = 0;
                endcase
            end
        end
        // edge channels latch rising edges until cleared (set wins); level channels follow the line
        m_pend = ((m_edge & ((m_pend & ~w1c) | (irq & ~m_prev))) | (~m_edge & irq)) & all;
        m_prev = irq;
        m_mask = nmask;
        m_edge = nedge;
    endfunction

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_dev_rd();
        for (int i = 0; i < int'(N_DEV); i++) bus.DEV_RD[i*DATA_W +: DATA_W] = dev_rd[i];
    endtask

    task automatic do_write(input int unsigned a, input int unsigned d,
                            output logic [N_DEV-1:0] we, output logic [1:0] daddr,
                            output logic [31:0] wd, output logic rdy);
        bus.PrAddr = a; bus.PrWD = d; bus.PrWe = 1'b1;
        #2;
        we = bus.DEV_We; daddr = bus.DEV_Addr; wd = bus.DEV_WD;
        tick();
        rdy = bus.PrReady;
        bus.PrWe = 1'b0;
        tick();
    endtask

    task automatic do_read(input int unsigned a, output logic [31:0] data, output logic rdy);
        bus.PrAddr = a; bus.PrRe = 1'b1;
        tick();
        data = bus.PrRD; rdy = bus.PrReady;
        bus.PrRe = 1'b0;
        tick();
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] d; logic r;
        apply_reset();
        n_checks++; if (bus.PrRD !== 32'h0) $display("FAIL reset_prrd: got %0h want 0", bus.PrRD); else n_pass++;
        n_checks++; if (bus.PrReady !== 1'b0) $display("FAIL reset_ready: got %0b want 0", bus.PrReady); else n_pass++;
        n_checks++; if (bus.DEV_We !== 3'b000) $display("FAIL reset_we: got %0b want 0", bus.DEV_We); else n_pass++;
        n_checks++; if (bus.HWInt !== 6'h0) $display("FAIL reset_hwint: got %0h want 0", bus.HWInt); else n_pass++;
        for (int k = 0; k < 3; k++) begin
            do_read(CTL + 32'(4 * k), d, r);
            n_checks++; if (d !== 32'h0 || r !== 1'b1) $display("FAIL reset_reg%0d: got %0h rdy %0b want 0 rdy 1", k, d, r); else n_pass++;
        end
    endtask

    task automatic test_dev_write();
        logic [N_DEV-1:0] we; logic [1:0] da; logic [31:0] wd, d; logic r;
        int unsigned s, off, data;
        do_write(32'h7F14, 32'h5A, we, da, wd, r);
        n_checks++; if (we !== 3'b010) $display("FAIL wr_we: got %0b want 010", we); else n_pass++;
        n_checks++; if (da !== 2'd1) $display("FAIL wr_addr: got %0d want 1", da); else n_pass++;
        n_checks++; if (wd !== 32'h5A) $display("FAIL wr_wd: got %0h want 5a", wd); else n_pass++;
        n_checks++; if (r !== 1'b1) $display("FAIL wr_ready: got %0b want 1", r); else n_pass++;
        n_checks++; if (bus.PrReady !== 1'b0) $display("FAIL wr_ready_pulse: got %0b want 0", bus.PrReady); else n_pass++;
        for (int k = 0; k < 8; k++) begin
            s = $urandom_range(0, N_DEV - 1); off = $urandom_range(0, 3); data = $urandom;
            do_write(BASE + 16 * s + 4 * off, data, we, da, wd, r);
            n_checks++;
            if (we !== 3'(1 << s) || da !== 2'(off) || wd !== data)
                $display("FAIL wr_rand%0d: got we %0b addr %0d wd %0h want we %0b addr %0d wd %0h", k, we, da, wd, 3'(1 << s), off, data);
            else n_pass++;
        end
        do_write(32'h8000, 32'hFFFF_FFFF, we, da, wd, r);
        n_checks++; if (we !== 3'b000 || r !== 1'b1) $display("FAIL wr_unmapped: got we %0b rdy %0b want 0 1", we, r); else n_pass++;
        d = exp_read(CTL + 12);
        n_checks++; if (d[31] !== 1'b1) $display("FAIL wr_unmapped_err_model: got %0b want 1", d[31]); else n_pass++;
    endtask

    task automatic test_dev_read();
        logic [N_DEV-1:0] we; logic [1:0] da; logic [31:0] wd, d, e; logic r;
        int unsigned s, a;
        apply_reset();
        for (int i = 0; i < int'(N_DEV); i++) dev_rd[i] = $urandom;
        dev_rd[2] = 32'h1234;
        set_dev_rd();
        do_read(32'h7F20, d, r);
        n_checks++; if (d !== 32'h1234 || r !== 1'b1) $display("FAIL rd_slot2: got %0h rdy %0b want 1234 1", d, r); else n_pass++;
        do_write(32'h7F00, 32'h77, we, da, wd, r);
        n_checks++; if (bus.PrRD !== 32'h1234) $display("FAIL rd_hold: got %0h want 1234", bus.PrRD); else n_pass++;
        for (int k = 0; k < 6; k++) begin
            s = $urandom_range(0, N_DEV - 1);
            a = BASE + 16 * s + 4 * $urandom_range(0, 3);
            e = exp_read(a);
            do_read(a, d, r);
            n_checks++; if (d !== e) $display("FAIL rd_rand%0d: got %0h want %0h", k, d, e); else n_pass++;
        end
        do_read(32'h8000, d, r);
        n_checks++; if (d !== 32'h0 || r !== 1'b1) $display("FAIL rd_unmapped: got %0h rdy %0b want 0 1", d, r); else n_pass++;
        do_read(CTL + 12, d, r);
        n_checks++; if (d[31] !== 1'b1) $display("FAIL rd_err_set: got %0b want 1", d[31]); else n_pass++;
        do_write(CTL + 12, 32'h0, we, da, wd, r);
        do_read(CTL + 12, d, r);
        n_checks++; if (d[31] !== 1'b0) $display("FAIL rd_err_clear: got %0b want 0", d[31]); else n_pass++;
        do_read(32'h7EFC, d, r);
        n_checks++; if (d !== 32'h0) $display("FAIL rd_below_base: got %0h want 0", d); else n_pass++;
        e = exp_read(CTL + 12);
        do_read(CTL + 12, d, r);
        n_checks++; if (d !== e || d[31] !== 1'b1) $display("FAIL rd_below_base_err: got %0h want %0h", d, e); else n_pass++;
    endtask

    task automatic test_edge();
        logic [N_DEV-1:0] we; logic [1:0] da; logic [31:0] wd, d; logic r;
        apply_reset();
        bus.DEV_IRQ = '0;
        do_write(CTL + 8, 32'h1, we, da, wd, r);
        do_write(CTL + 0, 32'h1, we, da, wd, r);
        bus.DEV_IRQ = 3'b001;
        tick();
        n_checks++; if (bus.HWInt !== 6'h0) $display("FAIL edge_hw_1cyc: got %0h want 0", bus.HWInt); else n_pass++;
        tick();
        n_checks++; if (bus.HWInt !== 6'h1) $display("FAIL edge_hw_2cyc: got %0h want 1", bus.HWInt); else n_pass++;
        bus.DEV_IRQ = '0;
        tick();
        do_read(CTL + 4, d, r);
        n_checks++; if (d !== 32'h1) $display("FAIL edge_latched: got %0h want 1", d); else n_pass++;
        do_write(CTL + 4, 32'h1, we, da, wd, r);
        do_read(CTL + 4, d, r);
        n_checks++; if (d !== 32'h0) $display("FAIL edge_w1c: got %0h want 0", d); else n_pass++;
        bus.DEV_IRQ = 3'b001;
        do_write(CTL + 4, 32'h1, we, da, wd, r);
        do_read(CTL + 4, d, r);
        n_checks++; if (d !== 32'h1) $display("FAIL edge_set_wins: got %0h want 1", d); else n_pass++;
        bus.DEV_IRQ = '0;
    endtask

    task automatic test_level();
        logic [N_DEV-1:0] we; logic [1:0] da; logic [31:0] wd, d; logic r;
        apply_reset();
        bus.DEV_IRQ = '0;
        do_write(CTL + 0, 32'h2, we, da, wd, r);
        bus.DEV_IRQ = 3'b010;
        tick(); tick();
        n_checks++; if (bus.HWInt !== 6'b000010) $display("FAIL level_hw: got %0b want 000010", bus.HWInt); else n_pass++;
        do_write(CTL + 4, 32'h2, we, da, wd, r);
        do_read(CTL + 4, d, r);
        n_checks++; if (d !== 32'h2) $display("FAIL level_w1c_ignored: got %0h want 2", d); else n_pass++;
        bus.DEV_IRQ = '0;
        tick();
        n_checks++; if (bus.HWInt !== 6'b000010) $display("FAIL level_drop_1cyc: got %0b want 000010", bus.HWInt); else n_pass++;
        tick();
        n_checks++; if (bus.HWInt !== 6'b000000) $display("FAIL level_drop_2cyc: got %0b want 0", bus.HWInt); else n_pass++;
    endtask

    task automatic test_prio();
        logic [N_DEV-1:0] we; logic [1:0] da; logic [31:0] wd, d; logic r;
        logic [5:0] exp_hw; logic [2:0] exp_vec;
`ifdef IRQ_PRIO_EN
        exp_hw = 6'b000010; exp_vec = 3'd2;
`else
        exp_hw = 6'b000110; exp_vec = 3'd0;
`endif
        apply_reset();
        bus.DEV_IRQ = '0;
        do_write(CTL + 0, 32'h7, we, da, wd, r);
        bus.DEV_IRQ = 3'b110;
        tick(); tick();
        n_checks++; if (bus.HWInt !== exp_hw) $display("FAIL prio_hw: got %0b want %0b", bus.HWInt, exp_hw); else n_pass++;
        do_read(CTL + 12, d, r);
        n_checks++; if (d[2:0] !== exp_vec || d[31] !== 1'b0) $display("FAIL prio_vector: got %0h want vec %0d", d, exp_vec); else n_pass++;
        bus.DEV_IRQ = '0;
    endtask

    task automatic test_reset_mid_access();
        rst = 1'b1;
        bus.PrAddr = BASE; bus.PrWD = 32'hABCD; bus.PrWe = 1'b1;
        #2;
        n_checks++; if (bus.DEV_We !== 3'b000) $display("FAIL rstmid_we: got %0b want 0", bus.DEV_We); else n_pass++;
        tick();
        n_checks++; if (bus.PrReady !== 1'b0) $display("FAIL rstmid_ready: got %0b want 0", bus.PrReady); else n_pass++;
        bus.PrWe = 1'b0; rst = 1'b0;
        tick();
        n_checks++; if (bus.PrReady !== 1'b0) $display("FAIL rstmid_noready: got %0b want 0", bus.PrReady); else n_pass++;
    endtask

    task automatic test_random_irq();
        logic [N_DEV-1:0] we; logic [1:0] da; logic [31:0] wd, d, e; logic r;
        int unsigned sel;
        apply_reset();
        for (int k = 0; k < 250; k++) begin
            bus.DEV_IRQ = 3'($urandom);
            sel = $urandom_range(0, 9);
            case (sel)
                0, 1, 2: begin
                    do_write(CTL + 4 * sel, $urandom, we, da, wd, r);
                    n_checks++; if (we !== 3'b000) $display("FAIL rnd_ctl_we%0d: got %0b want 0", k, we); else n_pass++;
                end
                3, 4: begin
                    e = exp_read(CTL + (sel == 3 ? 4 : 12));
                    do_read(CTL + (sel == 3 ? 4 : 12), d, r);
                    n_checks++; if (d !== e) $display("FAIL rnd_read%0d: got %0h want %0h", k, d, e); else n_pass++;
                end
                default: tick();
            endcase
            n_checks++;
            if (bus.HWInt !== 6'(m_hw)) $display("FAIL rnd_hwint%0d: got %0b want %0b", k, bus.HWInt, 6'(m_hw));
            else n_pass++;
        end
        bus.DEV_IRQ = '0;
    endtask

    initial begin
        rst = 1'b1;
        bus.PrAddr = '0; bus.PrWD = '0; bus.PrWe = 1'b0; bus.PrRe = 1'b0;
        bus.DEV_IRQ = '0;
        for (int i = 0; i < int'(N_DEV); i++) dev_rd[i] = 32'(i);
        set_dev_rd();
        test_reset();
        test_dev_write();
        test_dev_read();
        test_edge();
        test_level();
        test_prio();
        test_reset_mid_access();
        test_random_irq();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
